// File: rtl/alu_share_pkg.sv
// Shared definitions for the two-requester arithmetic unit: opcodes, FSM
// states and the round-robin grant helper.
package alu_share_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

  // A lone request always wins; on contention ptr names the favoured requester.
  function automatic logic [1:0] rr_grant(input logic [1:0] valid, input logic ptr);
    logic [1:0] g;
    case (valid)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = ptr ? 2'b10 : 2'b01;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request/response bundle between the two requesters (master) and the shared
// arithmetic controller (slave).
interface alu_share_ctrl_if #(parameter int WIDTH = 8);
  logic [1:0]         i_req_valid;
  logic [1:0]         o_req_ready;
  logic [3:0]         i_req_op;
  logic [2*WIDTH-1:0] i_req_a;
  logic [2*WIDTH-1:0] i_req_b;
  logic [1:0]         o_rsp_valid;
  logic [1:0]         i_rsp_ready;
  logic [WIDTH-1:0]   o_rsp_data;
  logic               o_rsp_err;
  logic               o_busy;

  modport master (
    output i_req_valid, i_req_op, i_req_a, i_req_b, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err, o_busy
  );

  modport slave (
    input  i_req_valid, i_req_op, i_req_a, i_req_b, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err, o_busy
  );
endinterface

// File: rtl/alu_share_ctrl_alu_core.sv
// Single-cycle add/sub/mul on the latched operands; results wrap modulo 2^WIDTH.
// Divide is iterated by the controller, so OP_DIV yields zero here.
module alu_core
  import alu_share_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  // Opcode decode; operand-width context keeps only the low WIDTH bits.
  always_comb begin
    result = {WIDTH{1'b0}};
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_MUL:  result = a * b;
      default: result = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin shares one WIDTH-bit add/sub/mul/div unit between two requesters,
// with a restoring divider that retires one quotient bit per cycle.
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             reset_n,
  alu_share_ctrl_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e             state_r;
  logic               ptr_r;
  logic               id_r;
  op_e                op_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   rem_r;
  logic [WIDTH-1:0]   quo_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [1:0]         rsp_valid_r;
  logic [WIDTH-1:0]   rsp_data_r;
  logic               rsp_err_r;
  logic               busy_r;

  logic [1:0]         grant_s;
  logic               gid_s;
  op_e                sel_op_s;
  logic [WIDTH-1:0]   sel_a_s;
  logic [WIDTH-1:0]   sel_b_s;
  logic [WIDTH-1:0]   core_res_s;
  logic [WIDTH:0]     rem_sh_s;
  logic [WIDTH-1:0]   rem_sub_s;
  logic [WIDTH-1:0]   rem_nxt_s;
  logic [WIDTH-1:0]   quo_nxt_s;
  logic               q_bit_s;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op     (op_r),
    .a      (a_r),
    .b      (b_r),
    .result (core_res_s)
  );

  // Grant is only offered while idle, so at most one transfer is in flight.
  always_comb begin
    if (state_r == IDLE) begin
      grant_s = rr_grant(bus.i_req_valid, ptr_r);
    end else begin
      grant_s = 2'b00;
    end
    gid_s    = grant_s[1];
    sel_op_s = gid_s ? op_e'(bus.i_req_op[3:2]) : op_e'(bus.i_req_op[1:0]);
    sel_a_s  = gid_s ? bus.i_req_a[2*WIDTH-1:WIDTH] : bus.i_req_a[WIDTH-1:0];
    sel_b_s  = gid_s ? bus.i_req_b[2*WIDTH-1:WIDTH] : bus.i_req_b[WIDTH-1:0];
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // The remainder stays below b, so the low WIDTH bits of the difference suffice.
  always_comb begin
    rem_sh_s  = {rem_r, quo_r[WIDTH-1]};
    rem_sub_s = rem_sh_s[WIDTH-1:0] - b_r;
    if (rem_sh_s >= {1'b0, b_r}) begin
      q_bit_s   = 1'b1;
      rem_nxt_s = rem_sub_s;
    end else begin
      q_bit_s   = 1'b0;
      rem_nxt_s = rem_sh_s[WIDTH-1:0];
    end
    quo_nxt_s = {quo_r[WIDTH-2:0], q_bit_s};
  end

  // Control FSM with registered response and busy outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      ptr_r       <= 1'b0;
      id_r        <= 1'b0;
      op_r        <= OP_ADD;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      rem_r       <= {WIDTH{1'b0}};
      quo_r       <= {WIDTH{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      rsp_valid_r <= 2'b00;
      rsp_data_r  <= {WIDTH{1'b0}};
      rsp_err_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_s != 2'b00) begin
            id_r    <= gid_s;
            op_r    <= sel_op_s;
            a_r     <= sel_a_s;
            b_r     <= sel_b_s;
            rem_r   <= {WIDTH{1'b0}};
            quo_r   <= sel_a_s;
            cnt_r   <= {CNT_W{1'b0}};
            ptr_r   <= ~gid_s;
            busy_r  <= 1'b1;
            state_r <= EXEC;
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          if (op_r == OP_DIV) begin
            if (b_r == {WIDTH{1'b0}}) begin
              rsp_data_r  <= {WIDTH{1'b1}};
              rsp_err_r   <= 1'b1;
              rsp_valid_r <= id_r ? 2'b10 : 2'b01;
              state_r     <= RESP;
            end else begin
              rem_r <= rem_nxt_s;
              quo_r <= quo_nxt_s;
              if (cnt_r == CNT_W'(WIDTH - 1)) begin
                rsp_data_r  <= quo_nxt_s;
                rsp_err_r   <= 1'b0;
                rsp_valid_r <= id_r ? 2'b10 : 2'b01;
                state_r     <= RESP;
              end else begin
                cnt_r <= cnt_r + CNT_W'(1);
              end
            end
          end else begin
            rsp_data_r  <= core_res_s;
            rsp_err_r   <= 1'b0;
            rsp_valid_r <= id_r ? 2'b10 : 2'b01;
            state_r     <= RESP;
          end
        end
        RESP: begin
          // Only the owning requester's ready completes the response.
          if (bus.i_rsp_ready[id_r]) begin
            rsp_valid_r <= 2'b00;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          rsp_valid_r <= 2'b00;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_req_ready = grant_s;
  assign bus.o_rsp_valid = rsp_valid_r;
  assign bus.o_rsp_data  = rsp_data_r;
  assign bus.o_rsp_err   = rsp_err_r;
  assign bus.o_busy      = busy_r;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed plus randomized bench for alu_share_ctrl against a transaction-level
// reference model: arithmetic from plain integers, timing as a cycle countdown.
module tb_alu_share_ctrl;
  import alu_share_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  alu_share_ctrl_if #(.WIDTH(W)) bus();
  alu_share_ctrl #(.WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int total = 0;
  int bad = 0;

  // Reference model state
  bit       m_busy, m_resp, m_id, m_ptr, m_rerr, m_err;
  int       m_cnt;
  logic [7:0] m_res, m_data;
  logic [1:0] last_ready;
  logic [1:0] gq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] ref_calc(input int op, input int a, input int b);
    int r;
    logic e;
    e = 1'b0;
    case (op)
      0: r = (a + b) % 256;
      1: r = (a - b + 256) % 256;
      2: r = (a * b) % 256;
      default: begin
        if (b == 0) begin r = 255; e = 1'b1; end
        else r = a / b;
      end
    endcase
    return {e, r[7:0]};
  endfunction

  task automatic check_outputs();
    chk("busy", {31'b0, bus.o_busy}, {31'b0, m_busy});
    chk("rsp_valid", {30'b0, bus.o_rsp_valid}, m_resp ? (m_id ? 32'd2 : 32'd1) : 32'd0);
    chk("rsp_data", {24'b0, bus.o_rsp_data}, {24'b0, m_data});
    chk("rsp_err", {31'b0, bus.o_rsp_err}, {31'b0, m_err});
  endtask

  // One clock: apply inputs, check grant, step past the edge, update model, check outputs.
  task automatic cyc(input logic [1:0] v, input logic [3:0] op, input logic [15:0] a,
                     input logic [15:0] b, input logic [1:0] rr);
    logic [1:0] eg;
    int opk, ak, bk;
    bit id;
    bus.i_req_valid = v;
    bus.i_req_op    = op;
    bus.i_req_a     = a;
    bus.i_req_b     = b;
    bus.i_rsp_ready = rr;
    #1;
    eg = 2'b00;
    if (!m_busy) begin
      if (v == 2'b01) eg = 2'b01;
      else if (v == 2'b10) eg = 2'b10;
      else if (v == 2'b11) eg = m_ptr ? 2'b10 : 2'b01;
      else eg = 2'b00;
    end
    last_ready = bus.o_req_ready;
    if (bus.o_req_ready != 2'b00) gq.push_back(bus.o_req_ready);
    chk("req_ready", {30'b0, bus.o_req_ready}, {30'b0, eg});
    @(posedge clk);
    #1;
    if (eg != 2'b00) begin
      id  = eg[1];
      opk = id ? int'(op[3:2]) : int'(op[1:0]);
      ak  = id ? int'(a[15:8]) : int'(a[7:0]);
      bk  = id ? int'(b[15:8]) : int'(b[7:0]);
      {m_rerr, m_res} = ref_calc(opk, ak, bk);
      m_cnt  = (opk == 3 && bk != 0) ? W : 1;
      m_busy = 1'b1;
      m_resp = 1'b0;
      m_id   = id;
      m_ptr  = ~id;
    end else if (m_busy && !m_resp) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_resp = 1'b1;
        m_data = m_res;
        m_err  = m_rerr;
      end
    end else if (m_resp && rr[m_id]) begin
      m_busy = 1'b0;
      m_resp = 1'b0;
    end
    check_outputs();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.i_req_valid = 2'b11;
    bus.i_rsp_ready = 2'b11;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_busy = 1'b0; m_resp = 1'b0; m_ptr = 1'b0;
    m_data = 8'd0; m_err = 1'b0; m_cnt = 0;
    check_outputs();
  endtask

  // Single transaction for requester k; reports accept-to-valid latency and busy cycles.
  task automatic txn(input bit k, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                     output int lat, output int busy_n);
    cyc(k ? 2'b10 : 2'b01, {op, op}, {a, a}, {b, b}, 2'b00);
    busy_n = int'(bus.o_busy);
    lat = 0;
    while (bus.o_rsp_valid == 2'b00 && lat < 20) begin
      cyc(2'b00, 4'd0, 16'd0, 16'd0, 2'b00);
      lat++;
      busy_n += int'(bus.o_busy);
    end
    chk("rsp_timeout", (lat < 20) ? 32'd1 : 32'd0, 32'd1);
    cyc(2'b00, 4'd0, 16'd0, 16'd0, 2'b11);
    busy_n += int'(bus.o_busy);
  endtask

  initial begin
    int lat, bn;
    bus.i_req_valid = 2'b00;
    bus.i_req_op    = 4'd0;
    bus.i_req_a     = 16'd0;
    bus.i_req_b     = 16'd0;
    bus.i_rsp_ready = 2'b00;
    m_res = 8'd0; m_rerr = 1'b0; m_id = 1'b0;
    do_reset();

    // 1: requester 0 add
    txn(1'b0, OP_ADD, 8'd20, 8'd10, lat, bn);
    chk("t1_lat", lat, 1);
    chk("t1_data", {24'b0, bus.o_rsp_data}, 32'd30);
    chk("t1_err", {31'b0, bus.o_rsp_err}, 32'd0);
    chk("t1_busy_cycles", bn, 2);

    // 2: requester 1 sub and mul
    txn(1'b1, OP_SUB, 8'd10, 8'd20, lat, bn);
    chk("t2_sub", {24'b0, bus.o_rsp_data}, 32'd246);
    txn(1'b1, OP_MUL, 8'd20, 8'd13, lat, bn);
    chk("t2_mul", {24'b0, bus.o_rsp_data}, 32'd4);

    // 3: divide and divide-by-zero
    txn(1'b0, OP_DIV, 8'd200, 8'd7, lat, bn);
    chk("t3_div_lat", lat, W);
    chk("t3_div_data", {24'b0, bus.o_rsp_data}, 32'd28);
    chk("t3_div_err", {31'b0, bus.o_rsp_err}, 32'd0);
    txn(1'b1, OP_DIV, 8'd5, 8'd0, lat, bn);
    chk("t3_dz_lat", lat, 1);
    chk("t3_dz_data", {24'b0, bus.o_rsp_data}, 32'd255);
    chk("t3_dz_err", {31'b0, bus.o_rsp_err}, 32'd1);

    // 4: both requesters continuously valid, grants alternate from 0
    do_reset();
    gq.delete();
    for (int i = 0; i < 12; i++) cyc(2'b11, 4'd0, 16'h0101, 16'h0101, 2'b11);
    chk("t4_grants", (gq.size() >= 4) ? 32'd1 : 32'd0, 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i < gq.size()) chk("t4_order", {30'b0, gq[i]}, (i % 2 == 0) ? 32'd1 : 32'd2);
    end

    // 5: response backpressure
    do_reset();
    cyc(2'b01, 4'd0, 16'h0305, 16'h0409, 2'b00);
    for (int i = 0; i < 6; i++) cyc(2'b11, 4'd0, 16'h0305, 16'h0409, 2'b00);
    chk("t5_hold_data", {24'b0, bus.o_rsp_data}, 32'd14);
    cyc(2'b11, 4'd0, 16'h0305, 16'h0409, 2'b01);
    cyc(2'b11, 4'd0, 16'h0305, 16'h0409, 2'b00);
    chk("t5_accept_after", {30'b0, last_ready}, 32'd2);
    for (int i = 0; i < 3; i++) cyc(2'b00, 4'd0, 16'd0, 16'd0, 2'b11);

    // 6: reset during a divide, then a fresh add
    cyc(2'b01, 4'b0011, 16'h00C8, 16'h0007, 2'b00);
    for (int i = 0; i < 3; i++) cyc(2'b00, 4'd0, 16'd0, 16'd0, 2'b11);
    do_reset();
    chk("t6_idle_valid", {30'b0, bus.o_rsp_valid}, 32'd0);
    for (int i = 0; i < 10; i++) cyc(2'b00, 4'd0, 16'd0, 16'd0, 2'b11);
    txn(1'b0, OP_ADD, 8'd3, 8'd4, lat, bn);
    chk("t6_add", {24'b0, bus.o_rsp_data}, 32'd7);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [15:0] rb;
      rb = 16'($urandom);
      if ($urandom_range(0, 7) == 0) rb[7:0] = 8'd0;
      if ($urandom_range(0, 7) == 0) rb[15:8] = 8'd0;
      cyc(2'($urandom_range(0, 3)), 4'($urandom), 16'($urandom), rb,
          2'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Shares one 8-bit arithmetic unit (add/sub/mul/div) between two requesters.
- Round-robin arbitration, valid/ready handshakes on both request and response.
- Registered results; iterative divide.
- Sits between requester logic and the arithmetic datapath; replaces direct per-requester instantiation of the combinational add/sub/mul/div units.

Parameters:
WIDTH, 8, operand/result width in bits; divide takes WIDTH cycles.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  synchronous active-low reset; one clock, reset is synchronous and active-low.
i_req_valid  input  2  bit k: requester k presents an operation.
o_req_ready  output  2  bit k: requester k's operation is accepted this cycle.
i_req_op  input  4  [2k+1:2k] opcode of requester k: 00 add, 01 sub, 10 mul, 11 div.
i_req_a  input  2*WIDTH  [k*WIDTH +: WIDTH] operand A of requester k.
i_req_b  input  2*WIDTH  [k*WIDTH +: WIDTH] operand B of requester k.
o_rsp_valid  output  2  bit k: result for requester k is available.
i_rsp_ready  input  2  bit k: requester k takes the result.
o_rsp_data  output  WIDTH  result; valid only while an o_rsp_valid bit is high.
o_rsp_err  output  1  divide-by-zero flag, qualified by o_rsp_valid.
o_busy  output  1  high when state is not IDLE.

Behaviour:
- Reset, sampled on posedge clk with reset_n=0:
  - State goes to IDLE; priority pointer goes to requester 0.
  - o_rsp_valid=0, o_rsp_data=0, o_rsp_err=0, o_busy=0.
  - Reset mid-operation abandons the operation; no response is issued.
- States: IDLE, EXEC, RESP.
- IDLE, grant:
  - o_req_ready is combinational, asserted only in IDLE and for one bit at most.
  - If only one valid is high, that requester is granted.
  - If both are high, the requester named by the priority pointer is granted.
  - The pointer moves to the other requester after every accepted transfer.
  - A valid dropped without ready creates no transaction.
- Accept edge (valid & ready): latch op, a, b and requester id; go to EXEC.
- EXEC, add/sub/mul: one cycle. Result is registered at the next edge and state goes to RESP, so o_rsp_valid rises 1 cycle after accept.
- EXEC, div:
  - Unsigned restoring shift-subtract, one quotient bit per cycle.
  - WIDTH cycles in EXEC; o_rsp_valid rises WIDTH cycles after accept.
  - b==0: no iteration, 1 cycle, result all ones, o_rsp_err=1.
- Arithmetic:
  - add, sub and mul results are modulo 2^WIDTH: sub wraps, mul keeps the low WIDTH bits.
  - div returns the quotient only.
  - o_rsp_err=0 for every op except divide-by-zero.
- RESP:
  - o_rsp_valid[id]=1; o_rsp_data and o_rsp_err stay stable until i_rsp_ready[id].
  - Handshake edge returns state to IDLE; i_rsp_ready of the other requester is ignored.
  - Minimum spacing between accepts is 3 cycles (accept, RESP, IDLE).
- o_rsp_data and o_rsp_err hold their last values after the handshake.

Decomposition:
- Package alu_share_pkg holds the opcode constants (OP_ADD, OP_SUB, OP_MUL, OP_DIV) and the state encoding (IDLE, EXEC, RESP).
- Sub-module alu_core: purely combinational WIDTH-bit add/sub/mul from registered operands.
- The divider iteration, arbiter and FSM stay in alu_share_ctrl.

Test Plan:
1. Requester 0, add a=20 b=10, i_rsp_ready=1 → o_rsp_valid[0] one cycle after accept, data=30, err=0; o_busy high for 2 cycles.
2. Requester 1, sub a=10 b=20 → data=246; then mul a=20 b=13 → data=4 (260 mod 256); o_rsp_valid[0] stays 0 throughout.
3. Div a=200 b=7 → o_rsp_valid 8 cycles after accept, data=28, err=0. Div a=5 b=0 → 1 cycle, data=255, err=1.
4. Both valid continuously after reset, add a=1 b=1 → grants alternate 0,1,0,1 starting with 0; each response goes only to its own requester.
5. Backpressure: hold i_rsp_ready=0 for 5 cycles in RESP → data and err stable, o_req_ready=0, no new accept; accept happens 1 cycle after the handshake.
6. Assert reset_n=0 during cycle 4 of a divide → next cycle all outputs 0, state IDLE, no response; a new add a=3 b=4 then returns 7.
